waveform_loader: RTL
====================

WAVEFORM_LOADER -- requirements
Module: waveform_loader

Interface
REQ-001 The block SHALL have parameter DATA_W, default 32, meaning stream data width in bits.
REQ-002 The block SHALL have parameter LEN_W, default 16, meaning waveform length field width in words.
REQ-003 The block SHALL have parameter TIMEOUT_CYCLES, default 1024, meaning the maximum number of cycles to wait for wf_write_ready.
REQ-004 The block SHALL use one clock and an asynchronous, active-high reset, with ports as follows.
- clk_in1  in  1  sole clock
- reset  in  1  asynchronous active-high reset
- start  in  1  single-cycle load request
- cfg_wf_len  in  LEN_W  waveform length in words
- cfg_param_hi  in  96  waveform parameter bits [127:32]
- waveform_parameters  out  128  parameter word presented to the waveform store
- init_wf_write  out  1  write-init request
- wf_write_ready  in  1  store accepted the write-init request
- src_axis_tdata  in  DATA_W  upstream sample data
- src_axis_tvalid  in  1  upstream valid
- src_axis_tready  out  1  upstream ready
- wfin_axis_tdata  out  DATA_W  downstream data
- wfin_axis_tvalid  out  1  downstream valid
- wfin_axis_tlast  out  1  last word of the waveform
- wfin_axis_tkeep  out  DATA_W/8  byte enables
- wfin_axis_tready  in  1  downstream ready
- busy  out  1  load in progress
- done  out  1  one-cycle pulse when the last word is accepted downstream
- err_len  out  1  one-cycle pulse when start is rejected for an illegal length
- err_timeout  out  1  one-cycle pulse when the init wait is aborted
- word_count  out  LEN_W  number of words accepted downstream in the current load

Function
REQ-005 The state machine SHALL have states IDLE, INIT, STREAM and FLUSH.
REQ-006 In IDLE, start with cfg_wf_len >= 2 SHALL latch cfg_wf_len and cfg_param_hi and move to INIT on the next edge.
REQ-007 In IDLE, start with cfg_wf_len < 2 SHALL pulse err_len for one cycle and leave the state in IDLE.
REQ-008 start asserted in any state other than IDLE SHALL be ignored.
REQ-009 waveform_parameters SHALL equal {latched cfg_param_hi, zero-extended latched length to 32 bits} and SHALL be held stable from INIT until the next accepted start.
REQ-010 init_wf_write SHALL be 1 throughout INIT.
REQ-011 A cycle in INIT with wf_write_ready = 1 SHALL move the state to STREAM and clear the timeout counter.
REQ-012 If INIT lasts TIMEOUT_CYCLES cycles without wf_write_ready, the block SHALL pulse err_timeout, return to IDLE, and emit no stream words.
REQ-013 src_axis_tready SHALL be 1 only in STREAM, only while fewer than length words have been taken from src, and only while the skid register is empty.
REQ-014 The path from src to wfin SHALL be a registered output stage plus a one-entry skid buffer.
- Latency: 1 cycle from src to wfin.
- Throughput: 1 word per cycle while wfin_axis_tready = 1.
- No data loss when wfin_axis_tready deasserts.
REQ-015 wfin_axis_tdata and wfin_axis_tlast SHALL hold their values while wfin_axis_tvalid = 1 and wfin_axis_tready = 0.
REQ-016 wfin_axis_tlast SHALL be 1 only on word index length-1.
REQ-017 wfin_axis_tkeep SHALL be all ones when wfin_axis_tvalid = 1, else 0.
REQ-018 word_count SHALL increment on each wfin handshake and SHALL clear on entry to INIT.
REQ-019 Once length words have been taken from src, the state SHALL move to FLUSH.
REQ-020 In FLUSH, the handshake carrying tlast SHALL pulse done in the same cycle and return the state to IDLE on the next edge.
REQ-021 busy SHALL be 1 in INIT, STREAM and FLUSH.
REQ-022 wf_write_ready asserted outside INIT SHALL be ignored.

Reset
REQ-023 Asserting reset SHALL immediately force the following, including in the middle of a load.
- State to IDLE.
- All counters to 0.
- Output and skid registers to empty.
- Outputs waveform_parameters = 0, init_wf_write = 0, src_axis_tready = 0, wfin_axis_tvalid = 0, wfin_axis_tlast = 0, wfin_axis_tkeep = 0, wfin_axis_tdata = 0, busy = 0, done = 0, err_len = 0, err_timeout = 0, word_count = 0.
REQ-024 After reset is deasserted, the block SHALL accept start on the first clock edge.

Structure
REQ-025 The state encoding and the 128-bit parameter field offsets (length at [31:0]) SHALL reside in shared package waveform_pkg.
REQ-026 The skid buffer SHALL be a separate sub-module, axis_skid_buf, parameterised by DATA_W.

Verification
REQ-027 The bench SHALL cover a basic load.
- Stimulus: cfg_wf_len = 128, cfg_param_hi = {32'h0, 32'h600, 32'h1}, wf_write_ready 3 cycles after init, src data 0..127 back-to-back, wfin_axis_tready = 1.
- Response: waveform_parameters = 128'h0_00000600_00000001_00000080; 128 words out in order; tlast only on data 127; done once; word_count = 128.
REQ-028 The bench SHALL cover backpressure.
- Stimulus: same load with wfin_axis_tready toggled on a random 50% duty.
- Response: 128 words, no drops or duplicates, data stable while stalled.
REQ-029 The bench SHALL cover an illegal length.
- Stimulus: start with cfg_wf_len = 1.
- Response: one err_len pulse, busy stays 0, no init_wf_write.
REQ-030 The bench SHALL cover the timeout.
- Stimulus: TIMEOUT_CYCLES = 16, wf_write_ready held at 0.
- Response: err_timeout on cycle 16 of INIT, return to IDLE, wfin_axis_tvalid never 1.
REQ-031 The bench SHALL cover reset mid-stream.
- Stimulus: reset asserted after 40 of 128 words.
- Response: all outputs at their reset values immediately; a following load of length 4 completes correctly.
REQ-032 The bench SHALL cover start while busy.
- Stimulus: start pulsed during STREAM with cfg_wf_len = 8.
- Response: ignored; the current 128-word load completes unchanged.

Source files
------------

// File: rtl/waveform_pkg.sv
// Shared definitions for the waveform loader: FSM encoding and the layout of
// the 128-bit parameter word handed to the waveform store.
package waveform_pkg;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_INIT,
        ST_STREAM,
        ST_FLUSH
    } wf_state_e;

    localparam int WF_PARAM_W = 128;
    localparam int WF_LEN_LSB = 0;
    localparam int WF_LEN_W   = 32;
    localparam int WF_HI_LSB  = 32;
    localparam int WF_HI_W    = 96;
    localparam int WF_MIN_LEN = 2;

    function automatic logic [WF_PARAM_W-1:0] wf_pack_params(
        input logic [WF_HI_W-1:0]  hi,
        input logic [WF_LEN_W-1:0] len
    );
        logic [WF_PARAM_W-1:0] p;
        p = '0;
        p[WF_HI_LSB  +: WF_HI_W]  = hi;
        p[WF_LEN_LSB +: WF_LEN_W] = len;
        return p;
    endfunction

endpackage

// File: rtl/axis_skid_buf.sv
// Registered AXI-Stream stage with a one-entry skid register; the upstream
// ready is a pure function of skid occupancy, so it never depends on m_ready.
module axis_skid_buf #(
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [DATA_W-1:0] s_data,
    input  logic              s_last,
    input  logic              s_valid,
    output logic              s_ready,
    output logic [DATA_W-1:0] m_data,
    output logic              m_last,
    output logic              m_valid,
    input  logic              m_ready
);

    logic [DATA_W-1:0] skid_data;
    logic              skid_last;
    logic              skid_valid;
    logic              out_free;

    assign s_ready  = !skid_valid;
    assign out_free = m_ready || !m_valid;

    // NOTE: datapath registers are reset too, so the stream outputs read as zero during reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            m_data     <= '0;
            m_last     <= 1'b0;
            m_valid    <= 1'b0;
            skid_data  <= '0;
            skid_last  <= 1'b0;
            skid_valid <= 1'b0;
        end else if (out_free) begin
            if (skid_valid) begin
                m_data     <= skid_data;
                m_last     <= skid_last;
                m_valid    <= 1'b1;
                skid_valid <= 1'b0;
            end else if (s_valid) begin
                m_data  <= s_data;
                m_last  <= s_last;
                m_valid <= 1'b1;
            end else begin
                m_last  <= 1'b0;
                m_valid <= 1'b0;
            end
        end else if (s_valid && s_ready) begin
            // Output is stalled: park the word that was already accepted.
            skid_data  <= s_data;
            skid_last  <= s_last;
            skid_valid <= 1'b1;
        end
    end

endmodule

// File: rtl/waveform_loader.sv
// Loads one waveform: requests a write-init from the store, then forwards
// exactly cfg_wf_len stream words with tlast on the final one.
module waveform_loader
    import waveform_pkg::*;
#(
    parameter int DATA_W         = 32,
    parameter int LEN_W          = 16,
    parameter int TIMEOUT_CYCLES = 1024
) (
    input  logic                  clk_in1,
    input  logic                  reset,
    input  logic                  start,
    input  logic [LEN_W-1:0]      cfg_wf_len,
    input  logic [WF_HI_W-1:0]    cfg_param_hi,
    output logic [WF_PARAM_W-1:0] waveform_parameters,
    output logic                  init_wf_write,
    input  logic                  wf_write_ready,
    input  logic [DATA_W-1:0]     src_axis_tdata,
    input  logic                  src_axis_tvalid,
    output logic                  src_axis_tready,
    output logic [DATA_W-1:0]     wfin_axis_tdata,
    output logic                  wfin_axis_tvalid,
    output logic                  wfin_axis_tlast,
    output logic [DATA_W/8-1:0]   wfin_axis_tkeep,
    input  logic                  wfin_axis_tready,
    output logic                  busy,
    output logic                  done,
    output logic                  err_len,
    output logic                  err_timeout,
    output logic [LEN_W-1:0]      word_count
);

    localparam int TMO_W = $clog2(TIMEOUT_CYCLES + 1);

    wf_state_e          state;
    logic [LEN_W-1:0]   len_q;
    logic [LEN_W-1:0]   taken_cnt;
    logic [WF_HI_W-1:0] param_hi_q;
    logic [TMO_W-1:0]   tmo_cnt;
    logic               err_len_q;
    logic               start_ok;
    logic               stream_open;
    logic               skid_ready;
    logic               src_hs;
    logic               wfin_hs;
    logic               last_take;
    logic               init_expired;

    assign start_ok     = start && (cfg_wf_len >= LEN_W'(WF_MIN_LEN));
    assign stream_open  = (state == ST_STREAM) && (taken_cnt < len_q);
    assign last_take    = (taken_cnt == len_q - LEN_W'(1));
    assign init_expired = (state == ST_INIT) && !wf_write_ready &&
                          (tmo_cnt == TMO_W'(TIMEOUT_CYCLES - 1));

    assign src_axis_tready     = stream_open && skid_ready;
    assign src_hs              = src_axis_tvalid && src_axis_tready;
    assign wfin_hs             = wfin_axis_tvalid && wfin_axis_tready;
    assign wfin_axis_tkeep     = {(DATA_W/8){wfin_axis_tvalid}};
    assign waveform_parameters = wf_pack_params(param_hi_q, WF_LEN_W'(len_q));
    assign init_wf_write       = (state == ST_INIT);
    assign busy                = (state != ST_IDLE);
    assign done                = (state == ST_FLUSH) && wfin_hs && wfin_axis_tlast;
    assign err_len             = err_len_q;
    assign err_timeout         = init_expired;

    axis_skid_buf #(
        .DATA_W (DATA_W)
    ) u_skid (
        .clk     (clk_in1),
        .rst     (reset),
        .s_data  (src_axis_tdata),
        .s_last  (last_take),
        .s_valid (src_axis_tvalid && stream_open),
        .s_ready (skid_ready),
        .m_data  (wfin_axis_tdata),
        .m_last  (wfin_axis_tlast),
        .m_valid (wfin_axis_tvalid),
        .m_ready (wfin_axis_tready)
    );

    // NOTE: all state updates use non-blocking assignments so every branch sees pre-edge values.
    always_ff @(posedge clk_in1 or posedge reset) begin
        if (reset) begin
            state      <= ST_IDLE;
            len_q      <= '0;
            param_hi_q <= '0;
            taken_cnt  <= '0;
            tmo_cnt    <= '0;
            word_count <= '0;
            err_len_q  <= 1'b0;
        end else begin
            err_len_q <= 1'b0;
            if (wfin_hs) begin
                word_count <= word_count + LEN_W'(1);
            end
            case (state)
                ST_IDLE: begin
                    if (start_ok) begin
                        len_q      <= cfg_wf_len;
                        param_hi_q <= cfg_param_hi;
                        taken_cnt  <= '0;
                        tmo_cnt    <= '0;
                        word_count <= '0;
                        state      <= ST_INIT;
                    end else if (start) begin
                        err_len_q <= 1'b1;
                    end
                end
                ST_INIT: begin
                    if (wf_write_ready) begin
                        tmo_cnt <= '0;
                        state   <= ST_STREAM;
                    end else if (init_expired) begin
                        tmo_cnt <= '0;
                        state   <= ST_IDLE;
                    end else begin
                        tmo_cnt <= tmo_cnt + TMO_W'(1);
                    end
                end
                ST_STREAM: begin
                    if (src_hs) begin
                        taken_cnt <= taken_cnt + LEN_W'(1);
                        if (last_take) begin
                            state <= ST_FLUSH;
                        end
                    end
                end
                ST_FLUSH: begin
                    if (done) begin
                        state <= ST_IDLE;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule
